truth_table_checker: RTL and testbench
======================================

# truth_table_checker

Hardware self-checking harness for small combinational exercise blocks. It sweeps every input combination of an N_IN-input function in ascending binary order and holds each vector for a settle interval. It samples the device's single output `f` and builds the observed truth table, then compares it against an expected table. It is the response side of our exhaustive truth-table benches, synthesizable so the check runs on-board, with pass/fail and first-mismatch reporting.

## Interface
- `N_IN`, 3, number of inputs of the checked function (1..6)
- `SETTLE`, 2, extra cycles each vector is held before sampling (0 allowed)
- `EXPECTED`, 8'hE2, expected truth table; bit i = f for input vector i; width 2**N_IN (default is f = (a&b)|(c&~b), vector = {a,b,c})

- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  run request, honoured only in IDLE
- `f_in`  in  1  output of the device under check
- `vec`  out  N_IN  applied input vector (MSB = first input, e.g. `a`)
- `busy`  out  1  sweep in progress
- `done`  out  1  one-cycle pulse when results become valid
- `pass`  out  1  captured == EXPECTED, valid from `done` until next accepted start
- `captured`  out  2**N_IN  observed truth table
- `err_count`  out  N_IN+1  number of mismatching vectors (0..2**N_IN)
- `first_err`  out  N_IN  lowest vector index that mismatched
- `first_err_valid`  out  1  at least one mismatch recorded

## Operation
- States: IDLE, APPLY, DONE.
- IDLE: `vec`=0, `busy`=0. `start`=1 at an edge → APPLY. In the same edge, clear `captured`, `err_count`, `first_err`, `first_err_valid`, `pass`, and set the settle counter to 0 and `busy`=1.
- APPLY: on each edge, if counter < SETTLE, increment the counter. If counter == SETTLE, do the following:
  - Write `f_in` into `captured[vec]`.
  - If `f_in` != `EXPECTED[vec]`, increment `err_count`. If `first_err_valid`=0, set `first_err`=`vec` and `first_err_valid`=1.
  - Clear the counter.
  - If `vec` is the last vector (2**N_IN−1), go to DONE. Otherwise increment `vec`.
- APPLY→DONE edge: `busy`=0, `done`=1, `pass` = (final captured == EXPECTED, including the bit sampled at that edge), `vec` returns to 0.
- DONE: lasts exactly one cycle, then → IDLE with `done`=0. `start` in DONE is ignored.
- `start` while `busy` is ignored; the sweep is not restarted.
- Results (`pass`, `captured`, `err_count`, `first_err*`) hold until the next accepted start.
- `err_count` cannot overflow: width N_IN+1 holds 2**N_IN.
- `f_in` is treated as a plain bit; no X handling.

## Timing
- Reset (async assert, any state): state=IDLE; `vec`=0, `busy`=0, `done`=0, `pass`=0, `captured`=0, `err_count`=0, `first_err`=0, `first_err_valid`=0. A sweep interrupted by reset is abandoned, with no `done`.
- Each vector is driven for SETTLE+1 cycles. `f_in` is sampled at the edge that ends the vector's last cycle.
- Latency: if start is accepted at edge E0, `done` goes high after edge E0 + 2**N_IN·(SETTLE+1). Defaults: 24 cycles.
- The earliest next start is accepted at edge E0 + 2**N_IN·(SETTLE+1) + 2, i.e. the first edge in IDLE.
- `vec` and all outputs are registered; none is combinational from inputs.

## Structure
- Shared package `ttc_pkg`: state encoding constants (IDLE/APPLY/DONE) and the default EXPECTED constant for the exercise functions.
- One natural sub-module, `ttc_sequencer`, containing the vector counter, settle counter and last-vector/sample-strobe generation. The top holds the FSM, capture and compare logic.

## Test plan
- Default params, model f=(a&b)|(c&~b) on `vec`, pulse start → `done` after 24 cycles; `captured`=8'hE2, `pass`=1, `err_count`=0, `first_err_valid`=0.
- Faulty model f=(a&b)|c → `captured`=8'hEA, `pass`=0, `err_count`=1, `first_err`=3, `first_err_valid`=1.
- SETTLE=0, f_in tied to 1 → `done` after 8 cycles; `captured`=8'hFF, `err_count`=4, `first_err`=0.
- Hold start high for the whole run plus the DONE cycle → exactly one `done` pulse; the second sweep begins only at the first IDLE edge. A start pulse mid-sweep does not shift `done`.
- Assert `rst` asynchronously while `vec`=5 → all outputs 0 immediately, no `done`. A later start gives a normal 24-cycle run with `pass`=1.
- N_IN=2, EXPECTED=4'h8 with an AND model → `done` after 12 cycles, `captured`=4'h8, `pass`=1.

Source files
------------

// File: rtl/ttc_pkg.sv
// Shared types and constants for the exhaustive truth-table checker.
// The default table is f = (a&b)|(c&~b) over {a,b,c}.
package ttc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [7:0] EXP_DEFAULT = 8'hE2;

endpackage

// File: rtl/ttc_sequencer.sv
// Vector and settle counters for the sweep.
// Produces the sample strobe and the last-vector flag.
module ttc_sequencer #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            run,
  output logic [N_IN-1:0] vec,
  output logic            sample,
  output logic            last
);

  localparam int CW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam logic [CW-1:0]   CMAX = CW'(SETTLE);
  localparam logic [N_IN-1:0] VMAX = '1;

  logic [CW-1:0] cnt;

  assign sample = run && (cnt == CMAX);
  assign last   = (vec == VMAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec <= '0;
      cnt <= '0;
    end else if (clear) begin
      vec <= '0;
      cnt <= '0;
    end else if (run) begin
      if (sample) begin
        cnt <= '0;
        vec <= last ? '0 : vec + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/truth_table_checker.sv
// Sweeps all input vectors, captures f_in per vector and
// compares the observed truth table against EXPECTED.
module truth_table_checker
  import ttc_pkg::*;
#(
  parameter int N_IN   = 3,
  parameter int SETTLE = 2,
  parameter logic [(1<<N_IN)-1:0] EXPECTED = EXP_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 f_in,
  output logic [N_IN-1:0]      vec,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [(1<<N_IN)-1:0] captured,
  output logic [N_IN:0]        err_count,
  output logic [N_IN-1:0]      first_err,
  output logic                 first_err_valid
);

  localparam int NV = 1 << N_IN;

  state_t          state;
  logic            accept;
  logic            run;
  logic            sample;
  logic            last;
  logic            miss;
  logic [NV-1:0]   cap_next;

  assign accept = (state == IDLE) && start;
  assign run    = (state == APPLY);
  assign miss   = f_in != EXPECTED[vec];

  // pass must include the bit sampled on the final edge
  always_comb begin
    cap_next      = captured;
    cap_next[vec] = f_in;
  end

  ttc_sequencer #(
    .N_IN   (N_IN),
    .SETTLE (SETTLE)
  ) u_seq (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept),
    .run    (run),
    .vec    (vec),
    .sample (sample),
    .last   (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      captured        <= '0;
      err_count       <= '0;
      first_err       <= '0;
      first_err_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state           <= APPLY;
            busy            <= 1'b1;
            pass            <= 1'b0;
            captured        <= '0;
            err_count       <= '0;
            first_err       <= '0;
            first_err_valid <= 1'b0;
          end
        end
        APPLY: begin
          if (sample) begin
            captured <= cap_next;
            if (miss) begin
              err_count <= err_count + 1'b1;
              if (!first_err_valid) begin
                first_err       <= vec;
                first_err_valid <= 1'b1;
              end
            end
            if (last) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (cap_next == EXPECTED);
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed scoreboard bench for truth_table_checker.
// Three instances cover default, SETTLE=0 and N_IN=2 builds.
module tb_truth_table_checker;

  typedef struct {
    logic [7:0] cap;
    logic       pass;
    logic [3:0] ec;
    logic [2:0] fe;
    logic       fev;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int mode [3];

  logic       start0 = 0, f0;
  logic [2:0] vec0;
  logic       busy0, done0, pass0, fev0;
  logic [7:0] cap0;
  logic [3:0] ec0;
  logic [2:0] fe0;

  logic       start1 = 0, f1;
  logic [2:0] vec1;
  logic       busy1, done1, pass1, fev1;
  logic [7:0] cap1;
  logic [3:0] ec1;
  logic [2:0] fe1;

  logic       start2 = 0, f2;
  logic [1:0] vec2;
  logic       busy2, done2, pass2, fev2;
  logic [3:0] cap2;
  logic [2:0] ec2;
  logic [1:0] fe2;

  truth_table_checker d0 (
    .clk(clk), .rst(rst), .start(start0), .f_in(f0),
    .vec(vec0), .busy(busy0), .done(done0), .pass(pass0),
    .captured(cap0), .err_count(ec0), .first_err(fe0),
    .first_err_valid(fev0)
  );

  truth_table_checker #(
    .N_IN(3), .SETTLE(0), .EXPECTED(8'hE2)
  ) d1 (
    .clk(clk), .rst(rst), .start(start1), .f_in(f1),
    .vec(vec1), .busy(busy1), .done(done1), .pass(pass1),
    .captured(cap1), .err_count(ec1), .first_err(fe1),
    .first_err_valid(fev1)
  );

  truth_table_checker #(
    .N_IN(2), .SETTLE(2), .EXPECTED(4'h8)
  ) d2 (
    .clk(clk), .rst(rst), .start(start2), .f_in(f2),
    .vec(vec2), .busy(busy2), .done(done2), .pass(pass2),
    .captured(cap2), .err_count(ec2), .first_err(fe2),
    .first_err_valid(fev2)
  );

  // 0: (a&b)|(c&~b)  1: (a&b)|c  2: const 1  3: 2-input AND
  function automatic logic model(int m, int v);
    logic a, b, c;
    a = v[2];
    b = v[1];
    c = v[0];
    case (m)
      0:       return (a & b) | (c & ~b);
      1:       return (a & b) | c;
      2:       return 1'b1;
      default: return b & c;
    endcase
  endfunction

  always_comb f0 = model(mode[0], int'(vec0));
  always_comb f1 = model(mode[1], int'(vec1));
  always_comb f2 = model(mode[2], int'(vec2));

  logic       done_u [3];
  logic       busy_u [3];
  logic       pass_u [3];
  logic       fev_u  [3];
  logic [7:0] cap_u  [3];
  logic [3:0] ec_u   [3];
  logic [2:0] fe_u   [3];
  logic [2:0] vec_u  [3];

  always_comb begin
    done_u[0] = done0; done_u[1] = done1; done_u[2] = done2;
    busy_u[0] = busy0; busy_u[1] = busy1; busy_u[2] = busy2;
    pass_u[0] = pass0; pass_u[1] = pass1; pass_u[2] = pass2;
    fev_u[0]  = fev0;  fev_u[1]  = fev1;  fev_u[2]  = fev2;
    cap_u[0]  = cap0;  cap_u[1]  = cap1;  cap_u[2]  = {4'h0, cap2};
    ec_u[0]   = ec0;   ec_u[1]   = ec1;   ec_u[2]   = {1'b0, ec2};
    fe_u[0]   = fe0;   fe_u[1]   = fe1;   fe_u[2]   = {1'b0, fe2};
    vec_u[0]  = vec0;  vec_u[1]  = vec1;  vec_u[2]  = {1'b0, vec2};
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(int u, logic v);
    case (u)
      0:       start0 = v;
      1:       start1 = v;
      default: start2 = v;
    endcase
  endtask

  function automatic exp_t predict(int m, int n,
                                   logic [7:0] tbl, int settle);
    exp_t e;
    logic b;
    e.cap = '0;
    e.ec  = '0;
    e.fe  = '0;
    e.fev = 1'b0;
    for (int v = 0; v < (1 << n); v++) begin
      b = model(m, v);
      e.cap[v] = b;
      if (b != tbl[v]) begin
        e.ec++;
        if (!e.fev) begin
          e.fe  = 3'(v);
          e.fev = 1'b1;
        end
      end
    end
    e.pass = (e.cap == tbl);
    e.lat  = (1 << n) * (settle + 1);
    return e;
  endfunction

  task automatic go(int u, int m, int n, logic [7:0] tbl, int settle);
    mode[u] = m;
    sb.push_back(predict(m, n, tbl, settle));
    set_start(u, 1'b1);
    @(negedge clk);
    set_start(u, 1'b0);
    chk("busy_after_start", 32'(busy_u[u]), 1);
  endtask

  task automatic cmp_results(string tag, int u, exp_t e);
    chk({tag, "_captured"}, 32'(cap_u[u]), 32'(e.cap));
    chk({tag, "_pass"}, 32'(pass_u[u]), 32'(e.pass));
    chk({tag, "_err_count"}, 32'(ec_u[u]), 32'(e.ec));
    chk({tag, "_first_err_valid"}, 32'(fev_u[u]), 32'(e.fev));
    if (e.fev) chk({tag, "_first_err"}, 32'(fe_u[u]), 32'(e.fe));
  endtask

  // Waits for done; optional mid-sweep start pulse at cycle mid_at.
  task automatic finish_run(string tag, int u, int mid_at);
    exp_t e;
    int k;
    e = sb.pop_front();
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (mid_at > 0) set_start(u, k == mid_at);
    end while (!done_u[u] && k < 200);
    set_start(u, 1'b0);
    chk({tag, "_latency"}, 32'(k), 32'(e.lat));
    cmp_results(tag, u, e);
    chk({tag, "_busy_done"}, 32'(busy_u[u]), 0);
    chk({tag, "_vec_done"}, 32'(vec_u[u]), 0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done_u[u]), 0);
    cmp_results({tag, "_hold"}, u, e);
  endtask

  initial begin
    exp_t e;
    int pulses;
    int k;
    mode[0] = 0;
    mode[1] = 0;
    mode[2] = 3;

    #1;
    chk("rst_vec", 32'(vec0), 0);
    chk("rst_busy", 32'(busy0), 0);
    chk("rst_done", 32'(done0), 0);
    chk("rst_pass", 32'(pass0), 0);
    chk("rst_captured", 32'(cap0), 0);
    chk("rst_err_count", 32'(ec0), 0);
    chk("rst_first_err", 32'(fe0), 0);
    chk("rst_first_err_valid", 32'(fev0), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    go(0, 0, 3, 8'hE2, 2);
    finish_run("good", 0, 0);

    go(0, 1, 3, 8'hE2, 2);
    finish_run("faulty", 0, 0);

    go(1, 2, 3, 8'hE2, 0);
    finish_run("settle0", 1, 0);

    go(0, 0, 3, 8'hE2, 2);
    finish_run("midstart", 0, 10);

    // start held through sweep and DONE: second sweep at first IDLE edge
    mode[0] = 0;
    sb.push_back(predict(0, 3, 8'hE2, 2));
    sb.push_back(predict(0, 3, 8'hE2, 2));
    start0 = 1'b1;
    @(negedge clk);
    pulses = 0;
    for (int i = 1; i <= 26; i++) begin
      @(negedge clk);
      if (done0) begin
        pulses++;
        chk("hold_latency", 32'(i), 24);
        e = sb.pop_front();
        cmp_results("hold1", 0, e);
      end
      if (i == 25) begin
        chk("hold_idle_busy", 32'(busy0), 0);
        chk("hold_idle_done", 32'(done0), 0);
      end
      if (i == 26) chk("hold_restart_busy", 32'(busy0), 1);
    end
    chk("hold_pulses", 32'(pulses), 1);
    start0 = 1'b0;
    finish_run("hold2", 0, 0);

    // asynchronous reset mid-sweep
    go(0, 0, 3, 8'hE2, 2);
    k = 0;
    while (vec0 != 3'd5 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("reach_vec5", 32'(vec0), 5);
    #1 rst = 1'b1;
    #1;
    chk("arst_vec", 32'(vec0), 0);
    chk("arst_busy", 32'(busy0), 0);
    chk("arst_captured", 32'(cap0), 0);
    chk("arst_err_count", 32'(ec0), 0);
    chk("arst_first_err_valid", 32'(fev0), 0);
    void'(sb.pop_back());
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i == 2) rst = 1'b0;
      if (done0) pulses++;
    end
    chk("arst_no_done", 32'(pulses), 0);

    go(0, 0, 3, 8'hE2, 2);
    finish_run("after_rst", 0, 0);

    go(2, 3, 2, 8'h08, 2);
    finish_run("n2_and", 2, 0);

    chk("scoreboard_empty", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
